mux32_8to1_arbiter: RTL and testbench
=====================================

# mux32_8to1_arbiter

Round-robin arbiter and sequencer for the shared 32-bit 8:1 operand/result mux. Eight requesters raise `req_i`; the block picks a winner, drives the mux select, captures the mux output into a registered output port with a valid/ready handshake, and returns a one-cycle grant to the winner. It sits between the requesting units and the downstream consumer, owning the mux `select_i` exclusively.

## Interface
- `DATA_W`, default 32: width of the mux data path and `data_o`.
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `rst_n_i`  in  1: reset, asynchronous, active-low.
- `req_i`  in  8: per-requester request; bit k held high with its data stable until `gnt_o[k]`.
- `sel_o`  out  3: registered select, wired to the mux `select_i`.
- `mux_data_i`  in  DATA_W: mux `data_o`, combinational from `sel_o`.
- `gnt_o`  out  8: one-hot, one-cycle grant pulse to the captured requester.
- `valid_o`  out  1: `data_o` and `src_o` hold a word.
- `ready_i`  in  1: consumer accepts the word when `valid_o && ready_i`.
- `data_o`  out  DATA_W: captured word.
- `src_o`  out  3: index of the requester that produced `data_o`.

## Operation
- State machine has three states: ARB, SEL and HOLD. Reset state is ARB.
- Round-robin pointer `last` is 3 bits and holds the most recently captured index. Its reset value is 7, so index 0 is searched first.
- ARB:
  - If `req_i == 0`, stay in ARB.
  - Otherwise the winner w is the first set bit searching `last+1, last+2, …` modulo 8, wrapping 7→0.
  - On the edge, `sel_o <= w`, then go to SEL.
- SEL (mux output settles from the registered `sel_o`):
  - If `req_i[sel_o]` is high:
    - Capture: `data_o <= mux_data_i`, `src_o <= sel_o`, `valid_o <= 1`.
    - Set `gnt_o <= 1 << sel_o`.
    - Update `last <= sel_o`, then go to HOLD.
  - If `req_i[sel_o]` has dropped, abort:
    - No capture, no grant, `last` unchanged.
    - Return to ARB.
- HOLD:
  - `gnt_o` is cleared after its first cycle, so it is a 1-cycle pulse.
  - `valid_o` stays high and `data_o`/`src_o` stay stable until `ready_i` is high.
  - On the edge where `ready_i` is high: `valid_o <= 0`, go to ARB.
- `sel_o` changes only on the ARB→SEL edge. It holds its value in SEL and HOLD.
- Requests arriving in SEL or HOLD are ignored until the next ARB.
- A requester that still holds `req_i` high after its grant competes again with the lowest round-robin priority.
- Async reset asserted mid-transfer: all state and outputs clear immediately. The word in flight is dropped and no grant is issued.

## Timing
- Reset values:
  - `sel_o` = 0, `gnt_o` = 0, `valid_o` = 0, `data_o` = 0, `src_o` = 0.
  - `last` = 7, state = ARB.
- Request seen in ARB in cycle 0:
  - `sel_o` valid in cycle 1 (SEL).
  - `valid_o`, `data_o`, `src_o` and `gnt_o` all valid in cycle 2.
  - Capture latency is 2 cycles.
- If `ready_i` is high in cycle 2, `valid_o` is low in cycle 3 and arbitration restarts.
- Peak throughput is 1 word per 3 cycles. Each extra cycle of `ready_i` low adds one cycle.
- `gnt_o` is high exactly in the first cycle of HOLD, regardless of `ready_i`.
- The `mux_data_i` path is combinational from `sel_o`. It must settle within one clock.

## Configuration
- `MUX32_ARB_PRIO0_EN` defined:
  - Requester 0 has fixed absolute priority: if `req_i[0]` is high in ARB, w = 0 irrespective of `last`.
  - Requesters 1..7 are round-robin among themselves; a capture from requester 0 does not update `last`.
- `MUX32_ARB_PRIO0_EN` undefined: pure round-robin over all 8 requesters, as described above.

## Test plan
- Reset mid-HOLD:
  - Stimulus: assert `rst_n_i`=0 while `valid_o`=1.
  - Response: all outputs read 0 immediately, without waiting for a clock edge.
  - After release with `req_i`=8'h01, `src_o`=0 and `gnt_o`=8'h01 in cycle 2.
- Single requester:
  - Stimulus: `req_i`=8'h08 with mux data 32'hDEADBEEF, `ready_i`=1.
  - Response: `sel_o`=3 in cycle 1.
  - In cycle 2: `valid_o`=1, `data_o`=32'hDEADBEEF, `src_o`=3, `gnt_o`=8'h08.
  - `valid_o`=0 in cycle 3.
- Round-robin wrap:
  - Stimulus: `req_i`=8'hFF held, each requester dropping its bit after its grant, `ready_i`=1.
  - Response: grant order 0,1,…,7.
  - Then `req_i`=8'h81 re-asserted: grant order 0 then 7 (pointer wrapped from 7).
- Backpressure:
  - Stimulus: `ready_i`=0 for 5 cycles after capture, with other requests pending.
  - Response: `data_o`/`src_o`/`sel_o` stable and `gnt_o` a single pulse.
  - Next capture starts 3 cycles after `ready_i` rises.
- Request drop in SEL:
  - Stimulus: `req_i[5]` deasserted in the SEL cycle.
  - Response: no grant, `valid_o` stays 0, state returns to ARB, `last` unchanged.
- Priority macro:
  - Stimulus: with `MUX32_ARB_PRIO0_EN` defined, hold `req_i`=8'h03.
  - Response: requester 0 granted every transfer while it keeps requesting.
  - With the macro undefined, the same stimulus alternates 0,1,0,1.

Source files
------------

// File: rtl/mux32_8to1_arbiter.sv
// Round-robin arbiter/sequencer owning the select of a shared 8:1 data mux.
// Optional build macro MUX32_ARB_PRIO0_EN gives requester 0 fixed absolute priority.
module mux32_8to1_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [7:0]        req_i,
    output logic [2:0]        sel_o,
    input  logic [DATA_W-1:0] mux_data_i,
    output logic [7:0]        gnt_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [2:0]        src_o
);

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_SEL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          last_q,  last_d;
    logic [2:0]          sel_q,   sel_d;
    logic [7:0]          gnt_q,   gnt_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [2:0]          src_q,   src_d;

    logic [7:0]          rr_req;
    logic [2:0]          cand_idx [8];
    logic [7:0]          cand_hit;
    logic [2:0]          win_idx;
    logic                capture_upd_last;

    // Requesters eligible for the rotating search
    always_comb begin
        rr_req = req_i;
`ifdef MUX32_ARB_PRIO0_EN
        rr_req[0] = 1'b0;
`endif
    end

    // Candidate gi is the (gi+1)-th index after the pointer, wrapping modulo 8
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cand
            assign cand_idx[gi] = last_q + 3'(gi + 1);
            assign cand_hit[gi] = rr_req[cand_idx[gi]];
        end
    endgenerate

    // Lowest-numbered hit wins: iterate downward so the nearest candidate is assigned last
    always_comb begin
        win_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cand_hit[i]) begin
                win_idx = cand_idx[i];
            end
        end
`ifdef MUX32_ARB_PRIO0_EN
        if (req_i[0]) begin
            win_idx = 3'd0;
        end
`endif
    end

`ifdef MUX32_ARB_PRIO0_EN
    assign capture_upd_last = (sel_q != 3'd0);
`else
    assign capture_upd_last = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        gnt_d   = 8'h00;
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;

        unique case (state_q)
            ST_ARB: begin
                if (req_i != 8'h00) begin
                    sel_d   = win_idx;
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                // A request withdrawn before capture aborts without touching the pointer
                if (req_i[sel_q]) begin
                    data_d  = mux_data_i;
                    src_d   = sel_q;
                    valid_d = 1'b1;
                    gnt_d   = 8'b1 << sel_q;
                    if (capture_upd_last) begin
                        last_d = sel_q;
                    end
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_HOLD: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_ARB;
            last_q  <= 3'd7;
            sel_q   <= 3'd0;
            gnt_q   <= 8'h00;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign sel_o   = sel_q;
    assign gnt_o   = gnt_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign src_o   = src_q;

endmodule

// File: tb/tb_mux32_8to1_arbiter.sv
// Directed-vector bench for mux32_8to1_arbiter with a behavioural 8:1 mux driven from sel_o.
module tb_mux32_8to1_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  req;
    logic [2:0]  sel;
    logic [31:0] mux_data;
    logic [7:0]  gnt;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic [2:0]  src;

    logic [31:0] mux_mem [8];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mux_data = mux_mem[sel];

    mux32_8to1_arbiter #(.DATA_W(32)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .req_i      (req),
        .sel_o      (sel),
        .mux_data_i (mux_data),
        .gnt_o      (gnt),
        .valid_o    (valid),
        .ready_i    (ready),
        .data_o     (data),
        .src_o      (src)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req   = 8'h00;
        ready = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    // Full transfer from ARB with ready high: SEL, HOLD (grant), back to ARB
    task automatic xfer(input int k, input bit drop, input string tag);
        logic [7:0] exp_gnt;
        exp_gnt = 8'h01 << k;
        tick;
        check({tag, " sel"}, 64'(sel), 64'(k));
        check({tag, " sel_valid"}, 64'(valid), 64'd0);
        tick;
        check({tag, " valid"}, 64'(valid), 64'd1);
        check({tag, " gnt"}, 64'(gnt), 64'(exp_gnt));
        check({tag, " src"}, 64'(src), 64'(k));
        check({tag, " data"}, 64'(data), 64'(mux_mem[k]));
        $display("xfer %s: src=%0d gnt=%02h data=%08h", tag, src, gnt, data);
        if (drop) req[k] = 1'b0;
        tick;
        check({tag, " valid_clr"}, 64'(valid), 64'd0);
        check({tag, " gnt_clr"}, 64'(gnt), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mux_mem[i] = 32'hC0DE_0000 + 32'(i);
        mux_mem[3] = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        req   = 8'h00;
        ready = 1'b0;
        #2;
        check("rst sel",   64'(sel),   64'd0);
        check("rst gnt",   64'(gnt),   64'd0);
        check("rst valid", 64'(valid), 64'd0);
        check("rst data",  64'(data),  64'd0);
        check("rst src",   64'(src),   64'd0);
        tick;
        rst_n = 1'b1;
        tick;

        // Single requester
        req = 8'h08; ready = 1'b1;
        xfer(3, 1'b1, "single");

        // Round-robin wrap from reset pointer
        do_reset;
        ready = 1'b1;
        req = 8'hFF;
        for (int k = 0; k < 8; k++) xfer(k, 1'b1, "rr");
        req = 8'h81;
        xfer(0, 1'b1, "wrap0");
        xfer(7, 1'b1, "wrap7");

        // Backpressure with another request pending
        do_reset;
        req = 8'h06; ready = 1'b0;
        tick;
        check("bp sel", 64'(sel), 64'd1);
        tick;
        check("bp gnt",  64'(gnt),   64'h02);
        check("bp valid", 64'(valid), 64'd1);
        $display("xfer bp: src=%0d gnt=%02h data=%08h", src, gnt, data);
        req = 8'h04;
        for (int c = 0; c < 5; c++) begin
            tick;
            check("bp hold gnt",   64'(gnt),   64'd0);
            check("bp hold valid", 64'(valid), 64'd1);
            check("bp hold data",  64'(data),  64'(mux_mem[1]));
            check("bp hold src",   64'(src),   64'd1);
            check("bp hold sel",   64'(sel),   64'd1);
        end
        ready = 1'b1;
        tick;
        check("bp release valid", 64'(valid), 64'd0);
        tick;
        check("bp next sel", 64'(sel), 64'd2);
        check("bp next early", 64'(valid), 64'd0);
        tick;
        check("bp next valid", 64'(valid), 64'd1);
        check("bp next src",   64'(src),   64'd2);
        check("bp next gnt",   64'(gnt),   64'h04);
        $display("xfer bp2: src=%0d gnt=%02h data=%08h", src, gnt, data);
        req = 8'h00;
        tick;

        // Request dropped in SEL: abort, pointer stays at 7
        do_reset;
        ready = 1'b1;
        req = 8'h20;
        tick;
        check("drop sel", 64'(sel), 64'd5);
        req = 8'h00;
        tick;
        check("drop valid", 64'(valid), 64'd0);
        check("drop gnt",   64'(gnt),   64'd0);
        tick;
        check("drop valid2", 64'(valid), 64'd0);
        check("drop gnt2",   64'(gnt),   64'd0);
        $display("xfer drop: aborted, valid=%0d gnt=%02h", valid, gnt);
        req = 8'h41;
        xfer(0, 1'b1, "drop_last");

        // Reset asserted mid-HOLD
        do_reset;
        req = 8'h01; ready = 1'b0;
        tick;
        tick;
        check("midrst pre valid", 64'(valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst valid", 64'(valid), 64'd0);
        check("midrst gnt",   64'(gnt),   64'd0);
        check("midrst data",  64'(data),  64'd0);
        check("midrst src",   64'(src),   64'd0);
        check("midrst sel",   64'(sel),   64'd0);
        $display("xfer midrst: outputs cleared valid=%0d data=%08h", valid, data);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        xfer(0, 1'b1, "post_rst");

        // Two persistent requesters
        do_reset;
        ready = 1'b1;
        req = 8'h03;
`ifdef MUX32_ARB_PRIO0_EN
        xfer(0, 1'b0, "prio a");
        xfer(0, 1'b0, "prio b");
        xfer(0, 1'b0, "prio c");
        xfer(0, 1'b0, "prio d");
`else
        xfer(0, 1'b0, "prio a");
        xfer(1, 1'b0, "prio b");
        xfer(0, 1'b0, "prio c");
        xfer(1, 1'b0, "prio d");
`endif
        req = 8'h00;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
